fios_result_collector: RTL and testbench
========================================

Name: fios_result_collector

Overview:
- Sits directly downstream of the last PE in the non-cascaded FIOS Montgomery multiplier chain.
- Captures the word-serial result stream (one WORD_WIDTH word per valid cycle, least-significant word first) into a full-width register.
- Presents the assembled product to the system with a valid/ready handshake.
- Flags stream overruns. Optionally computes the result ≥ modulus flag so software or a later stage can apply the final conditional subtraction.

Parameters:
- WORD_WIDTH, 17, width of one result word; matches the PE word width.
- WORD_COUNT, 8, number of words per result; must be ≥ 2.
- CNT_WIDTH, $clog2(WORD_COUNT+1), localparam; word counter width.

Ports:
- clock_i  in  1  system clock; all state updates on the rising edge.
- reset_n_i  in  1  asynchronous, active-low reset.
- res_valid_i  in  1  a result word is present on res_i this cycle.
- res_i  in  WORD_WIDTH  result word from the PE RES_o path, LSW first.
- p_i  in  WORD_WIDTH  modulus word aligned with res_i; used only with the optional feature.
- result_o  out  WORD_COUNT*WORD_WIDTH  assembled result; word k is at bits [k*WORD_WIDTH +: WORD_WIDTH].
- result_valid_o  out  1  result_o is complete and stable.
- result_ready_i  in  1  consumer accepts result_o.
- ge_p_o  out  1  result ≥ modulus; valid while result_valid_o = 1 (feature only, else tied 0).
- overrun_o  out  1  sticky: a word arrived while HOLD could not accept it.
- busy_o  out  1  state ≠ IDLE.

Behaviour:
- Reset (async assert, synchronous-to-clock deassert handled upstream):
  - state = IDLE, word counter = 0, result_o = 0.
  - result_valid_o = 0, ge_p_o = 0, overrun_o = 0, busy_o = 0.
- States: IDLE, COLLECT, HOLD.
- IDLE:
  - On res_valid_i, write res_i into word 0, counter = 1, go to COLLECT.
  - Otherwise stay in IDLE.
- COLLECT:
  - Each res_valid_i cycle writes res_i into word[counter] and increments the counter.
  - Cycles with res_valid_i = 0 are gaps: hold all state, no timeout.
  - When the word written has index WORD_COUNT-1, go to HOLD and reset the counter to 0.
- HOLD:
  - result_valid_o = 1 registered, i.e. asserted the cycle after the last word is captured (latency 1 cycle from the last res_valid_i).
  - result_o and ge_p_o are frozen while result_valid_o = 1 and result_ready_i = 0.
  - Transfer occurs when result_valid_o and result_ready_i are both 1. Next cycle result_valid_o = 0 and state = IDLE. result_o keeps its last value; it is not cleared.
- Simultaneous events in HOLD:
  - Transfer and res_valid_i in the same cycle: the new word is accepted as word 0, counter = 1, state goes straight to COLLECT. No bubble and no overrun.
  - res_valid_i without a transfer: the word is dropped, overrun_o is set to 1, and result_o is unchanged.
- overrun_o clears only on reset.
- Reset asserted mid-collection: the partial result is discarded and all outputs return to reset values immediately.
- Width rules:
  - res_i is stored unmodified.
  - No carry propagation is done here; the PE chain delivers reduced words.

Optional Feature:
- Macro: FIOS_COLLECT_GE_P_EN.
- Enabled: a serial subtract-with-borrow runs on every accepted word.
  - diff = {1'b0,res_i} - {1'b0,p_i} - borrow.
  - borrow_next = diff[WORD_WIDTH].
  - borrow is cleared when word 0 is accepted, i.e. borrow is treated as 0 for word 0.
  - After word WORD_COUNT-1, ge_p_o = ~borrow_next. It is registered together with result_valid_o, so both assert in the same cycle.
  - Equality gives ge_p_o = 1.
  - Gaps (res_valid_i = 0) hold the borrow.
- Disabled: no borrow logic, p_i is ignored, ge_p_o is constant 0.

Test Plan:
1. Reset with no input → all outputs 0. Then 8 back-to-back words 0x00001..0x00008 → result_valid_o rises 1 cycle after the 8th word; word k = k+1; busy_o = 1 from the first word until the transfer.
2. Result held with ready = 0 for 5 cycles, then ready = 1 → result_o stable throughout; valid drops the cycle after the transfer; state returns to IDLE.
3. Words with random 0–3-cycle gaps → same assembled value as scenario 1; valid latency is still 1 cycle after the last word.
4. In HOLD with ready = 0, one res_valid_i pulse → word dropped, overrun_o = 1 and stays 1. A transfer concurrent with a new word 0x1FFFF → no overrun; the next result has word 0 = 0x1FFFF.
5. Assert reset_n_i after 4 words → outputs clear asynchronously. After release, 8 fresh words assemble correctly with no stale data.
6. FIOS_COLLECT_GE_P_EN defined, p = all words 0x10000:
   - result = p → ge_p_o = 1.
   - result with top word 0x0FFFF, rest equal → ge_p_o = 0.
   - result with word 0 = 0x10001, rest equal → ge_p_o = 1.
   - Macro undefined → ge_p_o = 0.

Source files
------------

// File: rtl/fios_result_collector_if.sv
// Result-collector bus: PE result stream in, assembled product out with valid/ready.
// slave = collector side, master = the upstream PE plus the downstream consumer.
interface fios_result_collector_if #(
    parameter int WORD_WIDTH = 17,
    parameter int WORD_COUNT = 8
);
    logic                             res_valid_i;
    logic [WORD_WIDTH-1:0]            res_i;
    logic [WORD_WIDTH-1:0]            p_i;
    logic [WORD_COUNT*WORD_WIDTH-1:0] result_o;
    logic                             result_valid_o;
    logic                             result_ready_i;
    logic                             ge_p_o;

    modport slave (
        input  res_valid_i, res_i, p_i, result_ready_i,
        output result_o, result_valid_o, ge_p_o
    );

    modport master (
        output res_valid_i, res_i, p_i, result_ready_i,
        input  result_o, result_valid_o, ge_p_o
    );
endinterface

// File: rtl/fios_result_collector.sv
// Assembles the LSW-first FIOS result stream into a full-width word with valid/ready.
// Define FIOS_COLLECT_GE_P_EN to add the serial result >= modulus comparison.
module fios_result_collector #(
    parameter int WORD_WIDTH = 17,
    parameter int WORD_COUNT = 8
) (
    input  logic                  clock_i,
    input  logic                  reset_n_i,
    fios_result_collector_if.slave bus,
    output logic                  overrun_o,
    output logic                  busy_o
);
    localparam int CNT_WIDTH = $clog2(WORD_COUNT + 1);

    typedef enum logic [1:0] {IDLE, COLLECT, HOLD} state_t;

    state_t                 state_reg, state_next;
    logic [CNT_WIDTH-1:0]   cnt_reg, cnt_next;
    logic                   valid_reg, valid_next;
    logic                   ge_reg, ge_next;
    logic                   overrun_reg, overrun_next;
    logic                   xfer, accept, last_word, ge_final;
    logic [CNT_WIDTH-1:0]   wr_idx;

    assign xfer      = valid_reg & bus.result_ready_i;
    // HOLD only takes a new word when the held result leaves in the same cycle
    assign accept    = bus.res_valid_i & ((state_reg != HOLD) | xfer);
    assign wr_idx    = (state_reg == COLLECT) ? cnt_reg : '0;
    assign last_word = (state_reg == COLLECT) && (cnt_reg == CNT_WIDTH'(WORD_COUNT - 1));

`ifdef FIOS_COLLECT_GE_P_EN
    logic                  borrow_reg, borrow_in, borrow_next;
    logic [WORD_WIDTH:0]   diff;

    // word 0 always starts with no borrow, so the stale value never leaks in
    assign borrow_in   = (state_reg == COLLECT) ? borrow_reg : 1'b0;
    assign diff        = {1'b0, bus.res_i} - {1'b0, bus.p_i} - {{WORD_WIDTH{1'b0}}, borrow_in};
    assign borrow_next = diff[WORD_WIDTH];
    assign ge_final    = ~borrow_next;

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            borrow_reg <= 1'b0;
        end else if (accept) begin
            borrow_reg <= borrow_next;
        end
    end
`else
    logic unused_p;

    assign unused_p = ^bus.p_i;
    assign ge_final = 1'b0;
`endif

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            valid_reg   <= 1'b0;
            ge_reg      <= 1'b0;
            overrun_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            valid_reg   <= valid_next;
            ge_reg      <= ge_next;
            overrun_reg <= overrun_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        valid_next   = valid_reg;
        ge_next      = ge_reg;
        overrun_next = overrun_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    state_next = COLLECT;
                    cnt_next   = CNT_WIDTH'(1);
                end
            end
            COLLECT: begin
                if (accept) begin
                    if (last_word) begin
                        state_next = HOLD;
                        cnt_next   = '0;
                        valid_next = 1'b1;
                        ge_next    = ge_final;
                    end else begin
                        cnt_next = cnt_reg + CNT_WIDTH'(1);
                    end
                end
            end
            HOLD: begin
                if (xfer) begin
                    valid_next = 1'b0;
                    if (bus.res_valid_i) begin
                        state_next = COLLECT;
                        cnt_next   = CNT_WIDTH'(1);
                    end else begin
                        state_next = IDLE;
                    end
                end else if (bus.res_valid_i) begin
                    overrun_next = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
                valid_next = 1'b0;
            end
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < WORD_COUNT; gi = gi + 1) begin : g_word
            logic [WORD_WIDTH-1:0] word_reg;

            always_ff @(posedge clock_i or negedge reset_n_i) begin
                if (!reset_n_i) begin
                    word_reg <= '0;
                end else if (accept && (wr_idx == CNT_WIDTH'(gi))) begin
                    word_reg <= bus.res_i;
                end
            end

            assign bus.result_o[gi*WORD_WIDTH +: WORD_WIDTH] = word_reg;
        end
    endgenerate

    assign bus.result_valid_o = valid_reg;
    assign bus.ge_p_o         = ge_reg;
    assign overrun_o          = overrun_reg;
    assign busy_o             = (state_reg != IDLE);
endmodule

// File: tb/tb_fios_result_collector.sv
// Table-driven bench for fios_result_collector with a result scoreboard.
module tb_fios_result_collector;
    localparam int WW = 17;
    localparam int WC = 8;
    localparam int RW = WW * WC;
    localparam int NV = 8;
`ifdef FIOS_COLLECT_GE_P_EN
    localparam bit GE_EN = 1'b1;
`else
    localparam bit GE_EN = 1'b0;
`endif

    typedef struct {
        logic [RW-1:0] res;
        logic [RW-1:0] p;
        int            max_gap;
        int            hold;
        logic          exp_ge;
    } vec_t;

    typedef struct {
        logic [RW-1:0] res;
        logic          ge;
    } sb_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic overrun, busy;
    int   checks = 0;
    int   errors = 0;
    int   txn = 0;
    sb_t  sb[$];
    vec_t vecs[NV];

    fios_result_collector_if #(.WORD_WIDTH(WW), .WORD_COUNT(WC)) bus_if ();

    fios_result_collector #(.WORD_WIDTH(WW), .WORD_COUNT(WC)) dut (
        .clock_i   (clk),
        .reset_n_i (reset_n),
        .bus       (bus_if.slave),
        .overrun_o (overrun),
        .busy_o    (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [RW-1:0] fill(input logic [WW-1:0] v);
        logic [RW-1:0] r;
        for (int k = 0; k < WC; k++) r[k*WW +: WW] = v;
        return r;
    endfunction

    function automatic logic [RW-1:0] rand_res();
        logic [RW-1:0] r;
        for (int k = 0; k < WC; k++) r[k*WW +: WW] = WW'($urandom_range(0, 17'h1FFFF));
        return r;
    endfunction

    // scoreboard: results leave the DUT on valid && ready
    always @(negedge clk) begin
        if (reset_n && bus_if.result_valid_o && bus_if.result_ready_i) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_underflow: got unexpected result %h", bus_if.result_o);
            end else begin
                sb_t e;
                e = sb.pop_front();
                chk("sb_result", bus_if.result_o, e.res);
                chk("sb_ge", RW'(bus_if.ge_p_o), RW'(e.ge));
                $display("txn %0d result=%h ge=%b", txn, bus_if.result_o, bus_if.ge_p_o);
                txn++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input vec_t v, input bit concurrent);
        sb_t e;
        int  gaps;
        e.res = v.res;
        e.ge  = GE_EN ? v.exp_ge : 1'b0;
        sb.push_back(e);
        for (int k = 0; k < WC; k++) begin
            gaps = (v.max_gap > 0 && !(concurrent && k == 0)) ? $urandom_range(0, v.max_gap) : 0;
            repeat (gaps) begin
                bus_if.res_valid_i = 1'b0;
                tick();
                if (k > 0) begin
                    chk("valid_in_gap", RW'(bus_if.result_valid_o), RW'(0));
                    chk("busy_in_gap", RW'(busy), RW'(1));
                end
            end
            bus_if.res_valid_i = 1'b1;
            bus_if.res_i       = v.res[k*WW +: WW];
            bus_if.p_i         = v.p[k*WW +: WW];
            if (concurrent && k == 0) bus_if.result_ready_i = 1'b1;
            tick();
            bus_if.res_valid_i    = 1'b0;
            bus_if.result_ready_i = 1'b0;
            if (k == 0) chk("busy_first", RW'(busy), RW'(1));
            if (k < WC - 1) chk("valid_early", RW'(bus_if.result_valid_o), RW'(0));
        end
        chk("valid_latency", RW'(bus_if.result_valid_o), RW'(1));
    endtask

    task automatic take(input int hold, input vec_t v);
        for (int c = 0; c < hold; c++) begin
            tick();
            chk("hold_result", bus_if.result_o, v.res);
            chk("hold_valid", RW'(bus_if.result_valid_o), RW'(1));
            chk("hold_ge", RW'(bus_if.ge_p_o), RW'(GE_EN ? v.exp_ge : 1'b0));
        end
        bus_if.result_ready_i = 1'b1;
        tick();
        bus_if.result_ready_i = 1'b0;
        chk("valid_drop", RW'(bus_if.result_valid_o), RW'(0));
        chk("busy_idle", RW'(busy), RW'(0));
        chk("result_kept", bus_if.result_o, v.res);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_result"}, bus_if.result_o, '0);
        chk({tag, "_valid"}, RW'(bus_if.result_valid_o), RW'(0));
        chk({tag, "_ge"}, RW'(bus_if.ge_p_o), RW'(0));
        chk({tag, "_overrun"}, RW'(overrun), RW'(0));
        chk({tag, "_busy"}, RW'(busy), RW'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t va, vb, vc, vd;
        logic [RW-1:0] seq;
        logic [RW-1:0] pm;

        for (int k = 0; k < WC; k++) seq[k*WW +: WW] = WW'(k + 1);
        pm = fill(17'h10000);
        vecs[0] = '{res: seq, p: '0, max_gap: 0, hold: 5, exp_ge: 1'b1};
        vecs[1] = '{res: seq, p: '0, max_gap: 3, hold: 0, exp_ge: 1'b1};
        vecs[2] = '{res: pm, p: pm, max_gap: 1, hold: 1, exp_ge: 1'b1};
        vecs[3] = '{res: pm, p: pm, max_gap: 1, hold: 1, exp_ge: 1'b0};
        vecs[3].res[(WC-1)*WW +: WW] = 17'h0FFFF;
        vecs[4] = '{res: pm, p: pm, max_gap: 1, hold: 1, exp_ge: 1'b1};
        vecs[4].res[0 +: WW] = 17'h10001;
        for (int i = 5; i < NV; i++) begin
            vecs[i].res     = rand_res();
            vecs[i].p       = (i == 7) ? vecs[i].res : rand_res();
            if (i == 7) vecs[i].p[WW +: WW] = vecs[i].res[WW +: WW] ^ 17'h00001;
            vecs[i].max_gap = 2;
            vecs[i].hold    = 2;
            vecs[i].exp_ge  = (vecs[i].res >= vecs[i].p);
        end

        bus_if.res_valid_i    = 1'b0;
        bus_if.res_i          = '0;
        bus_if.p_i            = '0;
        bus_if.result_ready_i = 1'b0;
        #1;
        chk_reset_state("reset");
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        tick();
        chk_reset_state("idle");

        for (int i = 0; i < NV; i++) begin
            send(vecs[i], 1'b0);
            take(vecs[i].hold, vecs[i]);
        end

        // transfer and a new word 0 in the same cycle
        va = vecs[5];
        vb = '{res: rand_res(), p: pm, max_gap: 1, hold: 1, exp_ge: 1'b0};
        vb.res[0 +: WW] = 17'h1FFFF;
        vb.exp_ge = (vb.res >= vb.p);
        send(va, 1'b0);
        send(vb, 1'b1);
        chk("concurrent_no_overrun", RW'(overrun), RW'(0));
        take(1, vb);
        chk("concurrent_word0", RW'(bus_if.result_o[0 +: WW]), RW'(17'h1FFFF));

        // word arriving while the held result is not taken
        vc = vecs[6];
        send(vc, 1'b0);
        chk("pre_drop_overrun", RW'(overrun), RW'(0));
        bus_if.res_valid_i = 1'b1;
        bus_if.res_i       = 17'h0ABCD;
        tick();
        bus_if.res_valid_i = 1'b0;
        chk("drop_overrun", RW'(overrun), RW'(1));
        chk("drop_result", bus_if.result_o, vc.res);
        chk("drop_valid", RW'(bus_if.result_valid_o), RW'(1));
        take(2, vc);
        chk("overrun_sticky", RW'(overrun), RW'(1));

        // reset in the middle of a collection
        for (int k = 0; k < 4; k++) begin
            bus_if.res_valid_i = 1'b1;
            bus_if.res_i       = WW'(17'h15550 + k);
            tick();
        end
        bus_if.res_valid_i = 1'b0;
        chk("partial_busy", RW'(busy), RW'(1));
        #2 reset_n = 1'b0;
        #1;
        chk_reset_state("async_reset");
        tick();
        reset_n = 1'b1;
        vd = '{res: rand_res(), p: pm, max_gap: 1, hold: 1, exp_ge: 1'b0};
        vd.exp_ge = (vd.res >= vd.p);
        send(vd, 1'b0);
        take(1, vd);

        tick();
        chk("sb_empty", RW'(sb.size()), RW'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
